// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, fetches one word at a time over req/gnt + rvalid,
// and presents a registered {pc, instruction, valid} bundle to ID.
package instruction_fetch_pkg;
  localparam int RegWidth = 32;

  typedef struct packed {
    logic [RegWidth-1:0] pc;
    logic [RegWidth-1:0] instruction;
    logic                valid;
  } if_id_t;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;
endpackage

// Imem handshake: a request transfers on a cycle with oImemReq && iImemGnt;
// oImemReq/oImemAddr stay stable until then (only a redirect may move the
// address). Exactly one response (iImemRValid) follows each transfer, at least
// one cycle later. ID back-pressure: iStall=1 means oID is held unchanged.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [RegWidth-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [RegWidth-1:0] NOP_INS   = 32'h0000_0013
) (
  input  logic                iClk,
  input  logic                nRst,
  input  logic                iEn,
  input  logic                iStall,
  input  logic                iRedirect,
  input  logic [RegWidth-1:0] iRedirectPC,
  output logic                oImemReq,
  output logic [RegWidth-1:0] oImemAddr,
  input  logic                iImemGnt,
  input  logic                iImemRValid,
  input  logic [RegWidth-1:0] iImemRData,
  output if_id_t              oID,
  output logic [1:0]          oDbgState
);

  if_state_e           state_q, state_d;
  logic [RegWidth-1:0] pc_q, pc_d;
  logic                drop_q, drop_d;
  logic [RegWidth-1:0] skid_pc_q, skid_pc_d;
  logic [RegWidth-1:0] skid_ins_q, skid_ins_d;
  if_id_t              id_q, id_d;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IF_IDLE;
      pc_q       <= RESET_VEC;
      drop_q     <= 1'b0;
      skid_pc_q  <= RESET_VEC;
      skid_ins_q <= NOP_INS;
      id_q       <= '{pc: RESET_VEC, instruction: NOP_INS, valid: 1'b0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      skid_pc_q  <= skid_pc_d;
      skid_ins_q <= skid_ins_d;
      id_q       <= id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    skid_pc_d  = skid_pc_q;
    skid_ins_d = skid_ins_q;
    id_d       = id_q;

    // Unstalled ID consumes oID every cycle; default to a bubble.
    if (!iStall) begin
      id_d.valid       = 1'b0;
      id_d.instruction = NOP_INS;
    end

    case (state_q)
      IF_IDLE: if (iEn) state_d = IF_REQ;
      IF_REQ:  if (iImemGnt) state_d = IF_WAIT;
      IF_WAIT: begin
        if (iImemRValid) begin
          state_d = iEn ? IF_REQ : IF_IDLE;
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            pc_d = pc_q + 32'd4;
            if (iStall) begin
              skid_pc_d  = pc_q;
              skid_ins_d = iImemRData;
              state_d    = IF_HOLD;
            end else begin
              id_d = '{pc: pc_q, instruction: iImemRData, valid: 1'b1};
            end
          end
        end
      end
      IF_HOLD: begin
        if (!iStall) begin
          id_d    = '{pc: skid_pc_q, instruction: skid_ins_q, valid: 1'b1};
          state_d = iEn ? IF_REQ : IF_IDLE;
        end
      end
      default: state_d = IF_IDLE;
    endcase

    // A redirect wins over everything; a granted request still owes a
    // response, which must be swallowed via drop.
    if (iRedirect) begin
      pc_d             = iRedirectPC & ~32'h3;
      id_d.valid       = 1'b0;
      id_d.instruction = NOP_INS;
      case (state_q)
        IF_WAIT: begin
          if (iImemRValid) begin
            drop_d  = 1'b0;
            state_d = iEn ? IF_REQ : IF_IDLE;
          end else begin
            drop_d  = 1'b1;
            state_d = IF_WAIT;
          end
        end
        IF_REQ: begin
          if (iImemGnt) begin
            drop_d  = 1'b1;
            state_d = IF_WAIT;
          end else begin
            state_d = IF_REQ;
          end
        end
        default: state_d = iEn ? IF_REQ : IF_IDLE;
      endcase
    end
  end

  assign oImemReq  = (state_q == IF_REQ);
  assign oImemAddr = pc_q;
  assign oID       = id_q;
  assign oDbgState = state_q;

endmodule
